// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment receive path: active-low segment
// codes for hex digits and blank, checker FSM states, and the count-step helper.
package seg7_pkg;

   // Segment bus bit0=a .. bit6=g, active-low (0 = segment lit).
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {HUNT, RESYNC, TRACK} chk_state_e;

   // Digit expected to follow `digit`; 4-bit arithmetic gives the 0<->F wrap.
   function automatic logic [3:0] seg7_next(input logic [3:0] digit, input logic count_up);
      return count_up ? digit + 4'd1 : digit - 4'd1;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational seven-segment decoder: maps an active-low segment pattern back
// to its hex digit and flags whether it is a legal digit or the blank pattern.
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] digit,
   output logic       is_digit,
   output logic       is_blank
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      digit    = 4'h0;
      is_digit = 1'b1;
      is_blank = (pattern == SEG_BLANK);
      case (pattern)
         SEG_0:   digit = 4'h0;
         SEG_1:   digit = 4'h1;
         SEG_2:   digit = 4'h2;
         SEG_3:   digit = 4'h3;
         SEG_4:   digit = 4'h4;
         SEG_5:   digit = 4'h5;
         SEG_6:   digit = 4'h6;
         SEG_7:   digit = 4'h7;
         SEG_8:   digit = 4'h8;
         SEG_9:   digit = 4'h9;
         SEG_A:   digit = 4'hA;
         SEG_B:   digit = 4'hB;
         SEG_C:   digit = 4'hC;
         SEG_D:   digit = 4'hD;
         SEG_E:   digit = 4'hE;
         SEG_F:   digit = 4'hF;
         default: is_digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_sequence_checker.sv
// Receive-side checker for the down/up-counting seven-segment display: filters the
// bus for stability, decodes accepted patterns and verifies the count sequence.
module seg7_sequence_checker
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 1,
   parameter int COUNT_UP      = 0,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       display_segment,
   input  logic             clear_err,
   output logic [3:0]       value,
   output logic             valid,
   output logic             blank,
   output logic             locked,
   output logic             seq_error,
   output logic             code_error,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);
   localparam logic       COUNT_UP_B = (COUNT_UP != 0);

   logic [6:0] cand;
   logic [7:0] stab_cnt;
   chk_state_e state;
   logic [3:0] expected;
   logic [3:0] dec_digit;
   logic       dec_is_digit;
   logic       dec_is_blank;
   logic       accept;
   logic       mismatch;
   logic       err_evt;

   seg7_decoder u_decoder (
      .pattern  (display_segment),
      .digit    (dec_digit),
      .is_digit (dec_is_digit),
      .is_blank (dec_is_blank)
   );

   // Accept on the edge that completes the run; a saturated counter never re-accepts.
   assign accept   = (display_segment != cand) ? (STABLE_LIM == 8'd1)
                                               : (stab_cnt == STABLE_LIM - 8'd1);
   assign mismatch = dec_is_digit && (state != HUNT) && (dec_digit != expected);
   assign err_evt  = accept && (mismatch || (!dec_is_digit && !dec_is_blank));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cand     <= SEG_BLANK;
         stab_cnt <= STABLE_LIM;
      end else if (display_segment != cand) begin
         cand     <= display_segment;
         stab_cnt <= 8'd1;
      end else if (stab_cnt < STABLE_LIM) begin
         stab_cnt <= stab_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= HUNT;
         expected   <= 4'h0;
         value      <= 4'h0;
         valid      <= 1'b0;
         blank      <= 1'b0;
         locked     <= 1'b0;
         seq_error  <= 1'b0;
         code_error <= 1'b0;
      end else begin
         seq_error  <= 1'b0;
         code_error <= 1'b0;
         if (accept) begin
            if (dec_is_digit) begin
               value    <= dec_digit;
               valid    <= 1'b1;
               blank    <= 1'b0;
               expected <= seg7_next(dec_digit, COUNT_UP_B);
               if (state == HUNT || mismatch) begin
                  state     <= RESYNC;
                  locked    <= 1'b0;
                  seq_error <= mismatch;
               end else begin
                  state  <= TRACK;
                  locked <= 1'b1;
               end
            end else begin
               // Blank or illegal code: value holds, sequence tracking restarts.
               state      <= HUNT;
               locked     <= 1'b0;
               valid      <= 1'b0;
               blank      <= dec_is_blank;
               code_error <= !dec_is_blank;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count <= '0;
      end else if (clear_err) begin
         err_count <= '0;
      end else if (err_evt && (err_count != '1)) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// Self-checking bench: two checker instances (down/1-cycle and up/3-cycle filter)
// compared every cycle against a behavioural model plus directed literal checks.
module tb_seg7_sequence_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] ds_a = 7'h7F;
   logic [6:0] ds_b = 7'h7F;
   logic       clr_a = 1'b0;
   logic       clr_b = 1'b0;

   logic [3:0] value_a, value_b;
   logic       valid_a, valid_b, blank_a, blank_b, locked_a, locked_b;
   logic       seq_a, seq_b, code_a, code_b;
   logic [7:0] err_a, err_b;

   int total = 0;
   int bad   = 0;

   int codes [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                      'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

   typedef struct {
      logic [6:0] last;
      int         run;
      bit         have_prev;
      int         prev;
      bit         matched;
      int         value;
      bit         valid;
      bit         blank;
      bit         seq_err;
      bit         code_err;
      int         errs;
   } model_t;

   model_t ma, mb;

   seg7_sequence_checker #(.STABLE_CYCLES(1), .COUNT_UP(0), .ERR_W(8)) dut_a (
      .clk(clk), .reset(reset), .display_segment(ds_a), .clear_err(clr_a),
      .value(value_a), .valid(valid_a), .blank(blank_a), .locked(locked_a),
      .seq_error(seq_a), .code_error(code_a), .err_count(err_a)
   );

   seg7_sequence_checker #(.STABLE_CYCLES(3), .COUNT_UP(1), .ERR_W(8)) dut_b (
      .clk(clk), .reset(reset), .display_segment(ds_b), .clear_err(clr_b),
      .value(value_b), .valid(valid_b), .blank(blank_b), .locked(locked_b),
      .seq_error(seq_b), .code_error(code_b), .err_count(err_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic model_t model_reset(input int stable);
      model_t m;
      m.last = 7'h7F; m.run = stable; m.have_prev = 0; m.prev = 0; m.matched = 0;
      m.value = 0; m.valid = 0; m.blank = 0; m.seq_err = 0; m.code_err = 0; m.errs = 0;
      return m;
   endfunction

   // One clock edge of the observable behaviour: run-length acceptance, then
   // "does this digit follow the previous one" bookkeeping.
   function automatic model_t model_step(input model_t m, input logic [6:0] ds, input bit clr,
                                         input int stable, input bit up, input int err_max);
      int d;
      int nxt;
      m.seq_err  = 0;
      m.code_err = 0;
      if (ds == m.last) begin
         if (m.run < 1000) m.run++;
      end else begin
         m.last = ds;
         m.run  = 1;
      end
      if (m.run == stable) begin
         d = -1;
         for (int i = 0; i < 16; i++) if (codes[i] == int'(ds)) d = i;
         if (d >= 0) begin
            nxt = up ? (m.prev + 1) % 16 : (m.prev + 15) % 16;
            if (!m.have_prev)   m.matched = 0;
            else if (d == nxt)  m.matched = 1;
            else begin
               m.matched = 0;
               m.seq_err = 1;
            end
            m.have_prev = 1;
            m.prev  = d;
            m.value = d;
            m.valid = 1;
            m.blank = 0;
         end else begin
            m.have_prev = 0;
            m.matched   = 0;
            m.valid     = 0;
            m.blank     = (ds == 7'h7F);
            m.code_err  = (ds != 7'h7F);
         end
      end
      if (clr) m.errs = 0;
      else if ((m.seq_err || m.code_err) && m.errs < err_max) m.errs++;
      return m;
   endfunction

   initial begin
      ma = model_reset(1);
      mb = model_reset(3);
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma <= model_reset(1);
         mb <= model_reset(3);
      end else begin
         ma <= model_step(ma, ds_a, clr_a, 1, 1'b0, 255);
         mb <= model_step(mb, ds_b, clr_b, 3, 1'b1, 255);
      end
   end

   always @(negedge clk) begin
      check("a_value",  value_a, ma.value);
      check("a_valid",  valid_a, ma.valid);
      check("a_blank",  blank_a, ma.blank);
      check("a_locked", locked_a, ma.matched);
      check("a_seq",    seq_a,   ma.seq_err);
      check("a_code",   code_a,  ma.code_err);
      check("a_err",    err_a,   ma.errs);
      check("b_value",  value_b, mb.value);
      check("b_valid",  valid_b, mb.valid);
      check("b_blank",  blank_b, mb.blank);
      check("b_locked", locked_b, mb.matched);
      check("b_seq",    seq_b,   mb.seq_err);
      check("b_code",   code_b,  mb.code_err);
      check("b_err",    err_b,   mb.errs);
   end

   task automatic apply_a(input logic [6:0] p);
      @(negedge clk);
      ds_a = p;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_b(input logic [6:0] p);
      @(negedge clk);
      ds_b = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Full down-count with wrap back to F.
      for (int d = 15; d >= 0; d--) begin
         apply_a(7'(codes[d]));
         if (d == 15) check("seed_unlocked", locked_a, 0);
         if (d == 14) check("lock_on_E", locked_a, 1);
      end
      apply_a(7'(codes[15]));
      check("wrap_value", value_a, 4'hF);
      check("wrap_locked", locked_a, 1);
      check("p1_err", err_a, 0);

      // Blank restarts, then 5,4,7,6,5 with one sequence break.
      apply_a(7'h7F);
      check("blank_level", blank_a, 1);
      apply_a(7'(codes[5]));
      apply_a(7'(codes[4]));
      check("lock_54", locked_a, 1);
      apply_a(7'(codes[7]));
      check("seq_pulse", seq_a, 1);
      check("seq_unlock", locked_a, 0);
      apply_a(7'(codes[6]));
      check("relock_6", locked_a, 1);
      check("seq_one_cycle", seq_a, 0);
      apply_a(7'(codes[5]));
      check("err_one", err_a, 1);

      // Illegal code mid-sequence.
      apply_a(7'(codes[4]));
      apply_a(7'(codes[3]));
      apply_a(7'h55);
      check("code_pulse", code_a, 1);
      check("code_valid", valid_a, 0);
      check("code_hold", value_a, 3);
      check("code_unlock", locked_a, 0);
      apply_a(7'(codes[2]));
      check("reseed_unlocked", locked_a, 0);
      apply_a(7'(codes[1]));
      check("reseed_locked", locked_a, 1);
      check("err_two", err_a, 2);

      // Saturation, then clear_err racing an error.
      for (int i = 0; i < 256; i++) apply_a((i % 2 == 0) ? 7'h55 : 7'h56);
      check("err_sat", err_a, 255);
      @(negedge clk);
      ds_a  = 7'h55;
      clr_a = 1'b1;
      @(posedge clk);
      #1;
      check("clr_wins", err_a, 0);
      check("clr_code_pulse", code_a, 1);
      clr_a = 1'b0;
      apply_a(7'h56);
      check("err_after_clr", err_a, 1);

      // Async reset while locked at 9.
      apply_a(7'h7F);
      apply_a(7'(codes[11]));
      apply_a(7'(codes[10]));
      apply_a(7'(codes[9]));
      check("pre_rst_value", value_a, 9);
      check("pre_rst_locked", locked_a, 1);
      #2;
      reset = 1'b0;
      ds_a  = 7'h7F;
      #1;
      check("arst_value", value_a, 0);
      check("arst_valid", valid_a, 0);
      check("arst_blank", blank_a, 0);
      check("arst_locked", locked_a, 0);
      check("arst_seq", seq_a, 0);
      check("arst_code", code_a, 0);
      check("arst_err", err_a, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      apply_a(7'(codes[3]));
      check("post_rst_value", value_a, 3);
      check("post_rst_valid", valid_a, 1);
      check("post_rst_seq", seq_a, 0);
      check("post_rst_locked", locked_a, 0);

      // 3-cycle filter, count-up: glitch inside a held 0, then digit 1.
      apply_b(7'h40);
      apply_b(7'h40);
      apply_b(7'h00);
      apply_b(7'h40);
      apply_b(7'h40);
      check("glitch_no_accept", valid_b, 0);
      apply_b(7'h40);
      check("b_accept0_valid", valid_b, 1);
      check("b_accept0_value", value_b, 0);
      check("b_no_seq", seq_b, 0);
      apply_b(7'h79);
      apply_b(7'h79);
      check("b_hold_value", value_b, 0);
      apply_b(7'h79);
      check("b_third_edge", value_b, 1);
      check("b_locked_up", locked_b, 1);
      check("b_err", err_b, 0);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
